canny_pixel_writer: RTL and testbench

CANNY_PIXEL_WRITER -- requirements
Module: canny_pixel_writer

---
 rtl/canny_pixel_writer.sv | 184 ++++++++++++++++++
 tb/tb_canny_pixel_writer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_pixel_writer.sv
// -----------------------------------------------------------------------------
// canny_pixel_writer
//
// Packs 8-bit filtered edge pixels into 64-bit little-endian words and writes
// them to consecutive word addresses from STARTADDRESS to ENDADDRESS. After the
// word at ENDADDRESS has been written the block parks in a sticky DONE state
// until reset.
//
// Two word buffers decouple the pixel stream from memory stalls:
//   - The pack register assembles the next word. It may hold one complete word
//     while the output register is still busy.
//   - The output register drives writeData for the request in flight.
//
// Ports
//   clk           single clock, all state changes on the rising edge
//   reset         asynchronous, active-low reset
//   pixelValid    pixelData holds a valid pixel this cycle
//   pixelData     8-bit filtered edge pixel
//   pixelReady    a pixel offered this cycle is accepted at the next edge
//   flush         zero-pad the partial word and emit it
//   writeEn       write request to memory
//   writeAddress  word address of the current request (PIXW bits)
//   writeData     packed 64-bit pixel word
//   writeWait     memory stall; the request is held while high
//   done          the word at ENDADDRESS has been written
// -----------------------------------------------------------------------------
module canny_pixel_writer #(
    parameter int STARTADDRESS = 0,
    parameter int ENDADDRESS   = 2097151,
    parameter int PIXW         = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pixelValid,
    input  logic [7:0]      pixelData,
    output logic            pixelReady,
    input  logic            flush,
    output logic            writeEn,
    output logic [PIXW-1:0] writeAddress,
    output logic [63:0]     writeData,
    input  logic            writeWait,
    output logic            done
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [63:0]     r_pack;       // word being assembled (unfilled lanes stay zero)
    logic [2:0]      r_fill;       // pixels already in r_pack
    logic            r_pack_full;  // r_pack holds a complete word waiting for output
    logic [63:0]     r_out_data;   // word of the current/last request
    logic [PIXW-1:0] r_addr;

    logic            w_accept;
    logic            w_write_done;
    logic            w_last;
    logic            w_word_done;
    logic            w_out_free;
    logic            w_promote_new;
    logic            w_promote_pack;
    logic [63:0]     w_pack_next;

    assign w_accept     = pixelValid && pixelReady;
    assign w_write_done = (r_state == S_WRITE) && !writeWait;
    assign w_last       = (r_addr == PIXW'(ENDADDRESS));

    // A word completes on the 8th pixel, or on flush when at least one pixel
    // (including one accepted on this very edge) is in the word. Because the
    // pack register is cleared whenever a word leaves it, unfilled lanes are
    // already zero and padding needs no extra logic.
    assign w_word_done = (r_state != S_DONE) &&
                         ((w_accept && (r_fill == 3'd7)) ||
                          (flush && ((r_fill != 3'd0) || w_accept)));

    // The output register can take a word this edge if it is idle, or if the
    // current write completes now, is not the last one, and no older full
    // word is already queued ahead of it.
    assign w_out_free     = (r_state == S_EMPTY) ||
                            (w_write_done && !w_last && !r_pack_full);
    assign w_promote_new  = w_word_done && w_out_free;
    assign w_promote_pack = r_pack_full && w_write_done && !w_last;

    // Pack register with the current pixel (if any) dropped into its lane.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first so no path can leave it unassigned and infer a latch.
        w_pack_next = r_pack;
        if (w_accept) begin
            w_pack_next[{r_fill, 3'b000} +: 8] = pixelData;
        end
    end

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every flop samples pre-edge values regardless of block order.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_EMPTY: begin
                if (w_word_done) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_write_done) begin
                    if (w_last) begin
                        w_state_next = S_DONE;
                    end else if (r_pack_full || w_word_done) begin
                        w_state_next = S_WRITE;
                    end else begin
                        w_state_next = S_EMPTY;
                    end
                end
            end
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        writeEn    = (r_state == S_WRITE);
        done       = (r_state == S_DONE);
        // Stall the pixel stream only when both word buffers are occupied.
        pixelReady = reset && (r_state != S_DONE) &&
                     !(r_pack_full && (r_state == S_WRITE));
    end

    // ----------------------------------------------------------- datapath ---
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pack      <= '0;
            r_fill      <= '0;
            r_pack_full <= 1'b0;
            r_out_data  <= '0;
            r_addr      <= PIXW'(STARTADDRESS);
        end else begin
            if (w_word_done) begin
                r_fill <= 3'd0;
                if (w_promote_new) begin
                    r_pack      <= '0;
                    r_pack_full <= 1'b0;
                end else begin
                    r_pack      <= w_pack_next;
                    r_pack_full <= 1'b1;
                end
            end else if (w_promote_pack) begin
                r_pack      <= '0;
                r_pack_full <= 1'b0;
            end else if (w_accept) begin
                r_pack <= w_pack_next;
                r_fill <= r_fill + 3'd1;
            end

            // The queued full word is older than any word completing now.
            if (w_promote_pack) begin
                r_out_data <= r_pack;
            end else if (w_promote_new) begin
                r_out_data <= w_pack_next;
            end

            if (w_write_done) begin
                r_addr <= r_addr + PIXW'(1);
            end
        end
    end

    assign writeAddress = r_addr;
    assign writeData    = r_out_data;

endmodule

// File: tb/tb_canny_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_canny_pixel_writer
//
// Self-checking bench for canny_pixel_writer (STARTADDRESS=0, ENDADDRESS=1).
// A transaction-level model (queue of pending bytes, queue of completed words)
// predicts pixelReady, writeEn, writeData, writeAddress and done every cycle.
// A directed table and hand-written sequences cover the corner cases, then
// random episodes stress the stall/flush interplay.
// -----------------------------------------------------------------------------
module tb_canny_pixel_writer;

    localparam int START = 0;
    localparam int END_A = 1;
    localparam int PIXW  = 24;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            pixelValid = 1'b0;
    logic [7:0]      pixelData = 8'h00;
    logic            pixelReady;
    logic            flush = 1'b0;
    logic            writeEn;
    logic [PIXW-1:0] writeAddress;
    logic [63:0]     writeData;
    logic            writeWait = 1'b0;
    logic            done;

    canny_pixel_writer #(
        .STARTADDRESS(START),
        .ENDADDRESS  (END_A),
        .PIXW        (PIXW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixelValid  (pixelValid),
        .pixelData   (pixelData),
        .pixelReady  (pixelReady),
        .flush       (flush),
        .writeEn     (writeEn),
        .writeAddress(writeAddress),
        .writeData   (writeData),
        .writeWait   (writeWait),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model ---
    logic [7:0]  m_bytes[$];
    logic [63:0] m_words[$];   // front = word in the output register
    int          m_addr;
    bit          m_done;
    bit          m_we;
    bit          m_ready;

    task automatic model_reset();
        m_bytes.delete();
        m_words.delete();
        m_addr = START;
        m_done = 1'b0;
    endtask

    task automatic model_predict();
        m_we    = !m_done && (m_words.size() > 0);
        m_ready = !m_done && (m_words.size() < 2);
    endtask

    task automatic model_update(input logic v, input logic [7:0] d, input logic f, input logic w);
        logic [63:0] word;
        if (m_done) return;
        if (m_we && !w) begin
            void'(m_words.pop_front());
            if (m_addr == END_A) m_done = 1'b1;
            m_addr++;
        end
        if (v && m_ready) m_bytes.push_back(d);
        if ((m_bytes.size() == 8) || (f && (m_bytes.size() > 0))) begin
            word = '0;
            for (int i = 0; i < m_bytes.size(); i++) word[8*i +: 8] = m_bytes[i];
            m_words.push_back(word);
            m_bytes.delete();
        end
    endtask

    // Sampled DUT outputs of the most recent step, before its rising edge.
    logic        s_we, s_ready, s_done;
    logic [63:0] s_data;
    logic [PIXW-1:0] s_addr;

    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic w);
        @(negedge clk);
        pixelValid = v;
        pixelData  = d;
        flush      = f;
        writeWait  = w;
        #1;
        s_we    = writeEn;
        s_ready = pixelReady;
        s_done  = done;
        s_data  = writeData;
        s_addr  = writeAddress;
        model_predict();
        check("m_ready", s_ready, m_ready);
        check("m_we", s_we, m_we);
        check("m_done", s_done, m_done);
        if (m_we) begin
            check("m_data", s_data, m_words[0]);
            check("m_addr", s_addr, m_addr);
        end
        @(posedge clk);
        model_update(v, d, f, w);
    endtask

    task automatic do_reset(input logic w);
        @(negedge clk);
        pixelValid = 1'b0;
        flush      = 1'b0;
        writeWait  = w;
        #2 reset = 1'b0;
        #1;
        check("rst_we", writeEn, 1'b0);
        check("rst_ready", pixelReady, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", writeAddress, START);
        check("rst_data", writeData, 64'h0);
        model_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        writeWait = 1'b0;
    endtask

    // ------------------------------------------------------ table vectors ---
    typedef struct {
        logic            v;
        logic [7:0]      d;
        logic            f;
        logic            w;
        logic            e_we;
        logic            e_ready;
        logic            e_done;
        logic [63:0]     e_data;
        logic [PIXW-1:0] e_addr;
        bit              chk_data;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic f,
                                input logic w, input logic we, input logic rdy,
                                input logic dn, input logic [63:0] data,
                                input logic [PIXW-1:0] addr, input bit cd);
        vec_t r;
        r.v = v; r.d = d; r.f = f; r.w = w;
        r.e_we = we; r.e_ready = rdy; r.e_done = dn;
        r.e_data = data; r.e_addr = addr; r.chk_data = cd;
        return r;
    endfunction

    vec_t tbl[19];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_writes;

        // flush on empty pack, then 8 pixels, then 3 pixels + flush, then DONE
        tbl[0] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 0, 1'b0);
        for (int k = 0; k < 8; k++)
            tbl[1+k] = mk(1'b1, 8'(k + 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 0, 1'b0);
        tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0807060504030201, 0, 1'b1);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1, 1'b0);
        tbl[11] = mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1, 1'b0);
        tbl[12] = mk(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1, 1'b0);
        tbl[13] = mk(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1, 1'b0);
        tbl[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1, 1'b0);
        tbl[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0000000000CCBBAA, 1, 1'b1);
        tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 2, 1'b0);
        tbl[17] = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 2, 1'b0);
        tbl[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 2, 1'b0);

        do_reset(1'b0);
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].w);
            check($sformatf("tbl%0d_we", i), s_we, tbl[i].e_we);
            check($sformatf("tbl%0d_ready", i), s_ready, tbl[i].e_ready);
            check($sformatf("tbl%0d_done", i), s_done, tbl[i].e_done);
            check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            if (tbl[i].chk_data)
                check($sformatf("tbl%0d_data", i), s_data, tbl[i].e_data);
        end

        // Stall: 16 pixels under writeWait, pack fills behind the busy output.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hEE, 1'b0, 1'b1);
            check("stall_ready", s_ready, 1'b0);
            check("stall_we", s_we, 1'b1);
            check("stall_data", s_data, 64'h0807060504030201);
            check("stall_addr", s_addr, 0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("stall_w1_data", s_data, 64'h0807060504030201);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("stall_w2_we", s_we, 1'b1);
        check("stall_w2_data", s_data, 64'h100F0E0D0C0B0A09);
        check("stall_w2_addr", s_addr, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("stall_done", s_done, 1'b1);

        // 24 pixels at ENDADDRESS=1: two writes, third word never written.
        do_reset(1'b0);
        n_writes = 0;
        for (int i = 0; i < 30; i++) begin
            step(i < 24, 8'(8'h40 + i), 1'b0, 1'b0);
            if (s_we) n_writes++;
        end
        check("end_writes", n_writes, 2);
        check("end_done", s_done, 1'b1);
        check("end_ready", s_ready, 1'b0);
        check("end_we", s_we, 1'b0);

        // Flush with the 8th pixel: one full word, no padded extra.
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        step(1'b1, 8'h28, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("fl8_we", s_we, 1'b1);
        check("fl8_data", s_data, 64'h2827262524232221);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("fl8_no_extra", s_we, 1'b0);

        // Async reset mid-word with a stalled write in flight.
        do_reset(1'b0);
        for (int i = 0; i < 13; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
        check("pre_rst_we", s_we, 1'b1);
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_we", s_we, 1'b1);
        check("post_rst_addr", s_addr, START);
        check("post_rst_data", s_data, 64'h1817161514131211);

        // Random episodes checked by the model alone.
        for (int ep = 0; ep < 25; ep++) begin
            do_reset(1'b0);
            for (int c = 0; c < 80; c++)
                step($urandom_range(0, 9) < 7, 8'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
